uart_xmtr: RTL and testbench

UART transmitter subsystem. It is the transmit-side counterpart of the receiver subsystem.
- Host pushes bytes into an internal FIFO via a write strobe.
- A transmit FSM pops bytes and serialises each one onto `tx` as 8N1 frames (start bit, W data bits LSB-first, stop bit).
- The FSM is paced by the shared oversampling tick `s_tick`, which pulses 16 times per bit period.
- Sits between the bus-side register interface and the `tx` pad. It shares the baud generator with the receiver.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_xmtr_if.sv | 24 ++
 rtl/uart_tx.sv | 112 +++++++++++
 rtl/uart_xmtr.sv | 91 +++++++++
 tb/tb_uart_xmtr.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive subsystems.
// Holds the FSM state encoding, oversampling ratio and default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StStart = 2'b01,
        StData  = 2'b10,
        StStop  = 2'b11
    } tx_state_e;

    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned DEFAULT_W       = 8;
    localparam int unsigned DEFAULT_SB_TICK = 16;
    localparam int unsigned DEFAULT_ADDR_W  = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_xmtr_if.sv
// Host-side write port of the UART transmitter: write strobe, data and status flags.
interface uart_xmtr_if
    import uart_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) ();

    logic         wr_uart;
    logic [W-1:0] w_data;
    logic         tx_full;
    logic         tx_empty;
    logic         tx_busy;

    modport master (
        output wr_uart, w_data,
        input  tx_full, tx_empty, tx_busy
    );

    modport slave (
        input  wr_uart, w_data,
        output tx_full, tx_empty, tx_busy
    );

endinterface

// File: rtl/uart_tx.sv
// Serialising FSM: emits one 8N1-style frame per accepted word, paced by s_tick.
// tx and busy are registered from the next state so each level starts with its state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned W       = DEFAULT_W,
    parameter int unsigned SB_TICK = DEFAULT_SB_TICK
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_start,
    input  logic         s_tick,
    input  logic [W-1:0] din,
    output logic         tx_done_tick,
    output logic         tx,
    output logic         busy
);

    localparam int unsigned SW = cnt_width((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int unsigned NW = cnt_width(W);

    tx_state_e     state_q, state_d;
    logic [SW-1:0] s_cnt_q, s_cnt_d;
    logic [NW-1:0] n_cnt_q, n_cnt_d;
    logic [W-1:0]  b_q, b_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_cnt_d      = n_cnt_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
        case (state_q)
            StIdle: begin
                if (tx_start) begin
                    b_d     = din;
                    s_cnt_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = StData;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
                        s_cnt_d = '0;
                        b_d     = b_q >> 1;
                        if (n_cnt_q == NW'(W - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_cnt_q == SW'(SB_TICK - 1)) begin
                        state_d      = StIdle;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered, using the post-shift data word.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_xmtr.sv
// UART transmitter subsystem: host write FIFO feeding the serialising FSM.
// FIFO flags are registered from the next occupancy so no input reaches an output directly.
module uart_xmtr
    import uart_pkg::*;
#(
    parameter int unsigned W       = DEFAULT_W,
    parameter int unsigned SB_TICK = DEFAULT_SB_TICK,
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_tick,
    uart_xmtr_if.slave  bus,
    output logic        tx
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [W-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push, pop;
    logic              fsm_busy;
    logic              tx_done;

    // Full is judged on the registered flag, so a pop on the same edge never frees a slot early.
    assign push = bus.wr_uart && !full_q;
    assign pop  = !empty_q && !fsm_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (push && !pop) begin
            empty_d = 1'b0;
            full_d  = (wr_ptr_q + ADDR_W'(1)) == rd_ptr_q;
        end else if (pop && !push) begin
            full_d  = 1'b0;
            empty_d = (rd_ptr_q + ADDR_W'(1)) == wr_ptr_q;
        end
    end

    uart_tx #(
        .W       (W),
        .SB_TICK (SB_TICK)
    ) u_uart_tx (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (!empty_q),
        .s_tick       (s_tick),
        .din          (mem[rd_ptr_q]),
        .tx_done_tick (tx_done),
        .tx           (tx),
        .busy         (fsm_busy)
    );

    assign bus.tx_full  = full_q;
    assign bus.tx_empty = empty_q;
    assign bus.tx_busy  = fsm_busy;

    // A frame can only complete while the FSM reports a frame in progress.
    done_implies_busy: assert property (@(posedge clk) disable iff (!reset) tx_done |-> fsm_busy);

    if (DEPTH < 2) begin : g_depth_guard
        initial $fatal(1, "uart_xmtr: ADDR_W must be at least 1");
    end

endmodule

// File: tb/tb_uart_xmtr.sv
// Directed bench for uart_xmtr: frame shape, FIFO flags, back-to-back, stalled tick, reset.
module tb_uart_xmtr;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic s_tick = 1'b0;
    logic tick_en = 1'b0;
    int   div = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic tx16, tx32;

    uart_xmtr_if #(.W(8)) bus16 ();
    uart_xmtr_if #(.W(8)) bus32 ();

    uart_xmtr #(.W(8), .SB_TICK(16), .ADDR_W(4)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .bus    (bus16),
        .tx     (tx16)
    );

    uart_xmtr #(.W(8), .SB_TICK(32), .ADDR_W(4)) dut32 (
        .clk    (clk),
        .reset  (reset),
        .s_tick (s_tick),
        .bus    (bus32),
        .tx     (tx32)
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clk, launched just after the edge.
    always @(posedge clk) begin
        #1;
        s_tick = (tick_en && div == 3) ? 1'b1 : 1'b0;
        div    = (div == 3) ? 0 : div + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        return (sel != 0) ? tx32 : tx16;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? bus32.tx_busy : bus16.tx_busy;
    endfunction

    task automatic push(input int sel, input logic [7:0] d);
        if (sel != 0) begin
            bus32.wr_uart = 1'b1;
            bus32.w_data  = d;
        end else begin
            bus16.wr_uart = 1'b1;
            bus16.w_data  = d;
        end
        @(posedge clk);
        #1;
        bus16.wr_uart = 1'b0;
        bus32.wr_uart = 1'b0;
    endtask

    // Waits at most max_wait negedges for the start bit, then checks every clk of every bit.
    task automatic frame(input int sel, input string tag, input logic [7:0] data,
                         input int sb, input int max_wait);
        logic [9:0] bits;
        int waited = 0;
        bits = {1'b1, data, 1'b0};
        do begin
            @(negedge clk);
            waited++;
        end while (cur_tx(sel) === 1'b1 && waited < max_wait);
        check_eq($sformatf("%s start", tag), 32'(cur_tx(sel)), 32'd0);
        if (cur_tx(sel) !== 1'b0) return;
        for (int b = 0; b < 10; b++) begin
            int n = (b == 9) ? sb : 16;
            int mis = 0;
            int ticks = 0;
            int guard = 0;
            forever begin
                if (cur_tx(sel) !== bits[b] || cur_busy(sel) !== 1'b1) mis++;
                if (s_tick) ticks++;
                if (ticks == n) break;
                guard++;
                if (guard > 400) begin
                    mis++;
                    break;
                end
                @(negedge clk);
            end
            check_eq($sformatf("%s bit%0d", tag, b), 32'(mis), 32'd0);
            if (b < 9) @(negedge clk);
        end
    endtask

    // The single IDLE clk between back-to-back frames.
    task automatic gap(input int sel, input string tag);
        @(negedge clk);
        check_eq($sformatf("%s gap tx", tag), 32'(cur_tx(sel)), 32'd1);
        check_eq($sformatf("%s gap busy", tag), 32'(cur_busy(sel)), 32'd0);
    endtask

    task automatic idle_check(input int sel, input string tag, input int ncyc);
        int lows = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (cur_tx(sel) !== 1'b1) lows++;
        end
        check_eq(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;
        bus16.wr_uart = 1'b0;
        bus16.w_data  = '0;
        bus32.wr_uart = 1'b0;
        bus32.w_data  = '0;

        // Reset state
        #23;
        check_eq("rst tx", 32'(tx16), 32'd1);
        check_eq("rst empty", 32'(bus16.tx_empty), 32'd1);
        check_eq("rst full", 32'(bus16.tx_full), 32'd0);
        check_eq("rst busy", 32'(bus16.tx_busy), 32'd0);
        check_eq("rst tx32", 32'(tx32), 32'd1);
        @(negedge clk);
        reset   = 1'b1;
        tick_en = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5 latency and frame shape
        #1;
        push(0, 8'hA5);
        check_eq("a5 empty fall", 32'(bus16.tx_empty), 32'd0);
        @(negedge clk);
        check_eq("a5 tx before pop", 32'(tx16), 32'd1);
        @(posedge clk);
        #1;
        check_eq("a5 tx at pop", 32'(tx16), 32'd0);
        check_eq("a5 empty at pop", 32'(bus16.tx_empty), 32'd1);
        check_eq("a5 busy at pop", 32'(bus16.tx_busy), 32'd1);
        frame(0, "a5", 8'hA5, 16, 1);
        @(negedge clk);
        check_eq("a5 busy end", 32'(bus16.tx_busy), 32'd0);
        idle_check(0, "a5 idle", 20);

        // 0x00 then 0xFF back-to-back
        @(posedge clk);
        #1;
        push(0, 8'h00);
        push(0, 8'hFF);
        frame(0, "b00", 8'h00, 16, 2);
        gap(0, "b2b");
        frame(0, "bff", 8'hFF, 16, 1);
        @(negedge clk);
        check_eq("bff busy end", 32'(bus16.tx_busy), 32'd0);

        // Stalled tick: fill the FIFO behind 0x11
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(0, 8'h11);
        for (int i = 0; i < 15; i++) push(0, 8'(8'h20 + i));
        check_eq("fill 15 full", 32'(bus16.tx_full), 32'd0);
        push(0, 8'h2F);
        check_eq("fill 16 full", 32'(bus16.tx_full), 32'd1);
        push(0, 8'h30);
        check_eq("drop full", 32'(bus16.tx_full), 32'd1);
        check_eq("drop empty", 32'(bus16.tx_empty), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check_eq("frozen tx", 32'(tx16), 32'd0);
        check_eq("frozen busy", 32'(bus16.tx_busy), 32'd1);
        tick_en = 1'b1;
        frame(0, "f11", 8'h11, 16, 1);

        // Write while full lands on the pop edge and must be dropped
        @(posedge clk);
        #1;
        check_eq("pop-edge idle tx", 32'(tx16), 32'd1);
        check_eq("pop-edge full", 32'(bus16.tx_full), 32'd1);
        bus16.wr_uart = 1'b1;
        bus16.w_data  = 8'h99;
        @(posedge clk);
        #1;
        bus16.wr_uart = 1'b0;
        check_eq("pop-edge full after", 32'(bus16.tx_full), 32'd0);
        check_eq("pop-edge tx", 32'(tx16), 32'd0);
        for (int i = 0; i < 16; i++) begin
            frame(0, $sformatf("q%0h", 8'h20 + i), 8'(8'h20 + i), 16, 1);
            if (i < 15) gap(0, $sformatf("q%0h", 8'h20 + i));
        end
        @(negedge clk);
        check_eq("q busy end", 32'(bus16.tx_busy), 32'd0);
        idle_check(0, "q no extra frame", 200);
        check_eq("q empty end", 32'(bus16.tx_empty), 32'd1);

        // Reset during DATA bit 3 of 0x5A with 3 queued
        @(posedge clk);
        #1;
        push(0, 8'h5A);
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tx16 === 1'b1 && guard < 20);
        cnt = 0;
        guard = 0;
        forever begin
            if (s_tick) cnt++;
            if (cnt == 72 || guard > 1000) break;
            guard++;
            @(negedge clk);
        end
        check_eq("pre-rst busy", 32'(bus16.tx_busy), 32'd1);
        check_eq("pre-rst empty", 32'(bus16.tx_empty), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("async rst tx", 32'(tx16), 32'd1);
        check_eq("async rst empty", 32'(bus16.tx_empty), 32'd1);
        check_eq("async rst busy", 32'(bus16.tx_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle_check(0, "post-rst idle", 300);
        check_eq("post-rst empty", 32'(bus16.tx_empty), 32'd1);
        @(posedge clk);
        #1;
        push(0, 8'h3C);
        frame(0, "r3c", 8'h3C, 16, 3);

        // Two stop bits build
        @(posedge clk);
        #1;
        push(1, 8'hC3);
        frame(1, "c3", 8'hC3, 32, 3);
        @(negedge clk);
        check_eq("c3 busy after stop", 32'(bus32.tx_busy), 32'd0);
        check_eq("c3 tx after stop", 32'(tx32), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
